cl_sym_decoder: RTL and testbench

CL_SYM_DECODER -- requirements
Module: cl_sym_decoder

---
 rtl/cl_sym_decoder.sv | 169 ++++++++++++++++
 tb/tb_cl_sym_decoder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_sym_decoder.sv
// Serial canonical-prefix-code decoder: loads a 29-entry code-length table, drives an external
// table builder, then decodes a bitstream one bit per two cycles. Define CL_DEC_STAT_EN for sym_cnt.
module cl_sym_decoder (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  input  logic         len_valid,
  input  logic [3:0]   len_data,
  output logic         len_ready,
  output logic         bld_rst_n,
  output logic         bld_enb,
  output logic [115:0] bld_tree,
  input  logic         bld_fin,
  output logic [3:0]   bld_len,
  input  logic [4:0]   bld_count,
  output logic [7:0]   bld_code,
  input  logic [4:0]   bld_symb,
  input  logic         bit_valid,
  input  logic         bit_in,
  output logic         bit_ready,
  output logic         sym_valid,
  output logic [4:0]   sym_out,
  input  logic         sym_ready,
  output logic         err,
  output logic [15:0]  sym_cnt
);

  typedef enum logic [2:0] {
    StIdle, StLoad, StClr, StBuild, StDec, StChk, StOut, StErr
  } state_e;

  state_e         state_q, state_d;
  logic [4:0]     idx_q, idx_d;
  logic [7:0]     code_q, code_d;
  logic [7:0]     first_q, first_d;
  logic [3:0]     len_q, len_d;
  logic [115:0]   tree_q, tree_d;
  logic [4:0]     sym_q, sym_d;
  logic           rst_dly_q;
  logic [7:0]     count_ext;
  logic           restart;

  assign count_ext = {3'b000, bld_count};
  assign restart   = start && (state_q != StLoad);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    code_d    = code_q;
    first_d   = first_q;
    len_d     = len_q;
    tree_d    = tree_q;
    sym_d     = sym_q;
    len_ready = 1'b0;
    bit_ready = 1'b0;
    sym_valid = 1'b0;
    bld_enb   = 1'b0;
    err       = 1'b0;
    bld_len   = 4'd0;
    case (state_q)
      StIdle: ;
      StLoad: begin
        len_ready = 1'b1;
        if (len_valid) begin
          tree_d[{idx_q, 2'b00} +: 4] = len_data;
          idx_d = idx_q + 5'd1;
          if (idx_q == 5'd28) state_d = StClr;
        end
      end
      StClr: state_d = StBuild;
      StBuild: begin
        bld_enb = 1'b1;
        code_d  = 8'd0;
        first_d = 8'd0;
        len_d   = 4'd0;
        if (bld_fin) state_d = StDec;
      end
      StDec: begin
        bit_ready = 1'b1;
        bld_len   = len_q;
        if (bit_valid) begin
          code_d  = {code_q[6:0], bit_in};
          // first code of the next length, from the count at the current length
          first_d = (first_q + count_ext) << 1;
          len_d   = len_q + 4'd1;
          state_d = StChk;
        end
      end
      StChk: begin
        bld_len = len_q;
        if ((code_q - first_q) < count_ext) begin
          sym_d   = bld_symb;
          state_d = StOut;
        end else if (len_q == 4'd8) begin
          state_d = StErr;
        end else begin
          state_d = StDec;
        end
      end
      StOut: begin
        sym_valid = 1'b1;
        if (sym_ready) begin
          code_d  = 8'd0;
          first_d = 8'd0;
          len_d   = 4'd0;
          state_d = StDec;
        end
      end
      StErr: err = 1'b1;
      default: state_d = StIdle;
    endcase
    if (restart) begin
      state_d = StLoad;
      idx_d   = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    rst_dly_q <= rst;
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 5'd0;
      code_q  <= 8'd0;
      first_q <= 8'd0;
      len_q   <= 4'd0;
      tree_q  <= '0;
      sym_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      first_q <= first_d;
      len_q   <= len_d;
      tree_q  <= tree_d;
      sym_q   <= sym_d;
    end
  end

  // Builder reset also covers the cycle after rst so it sees a full reset cycle.
  assign bld_rst_n = !(rst || rst_dly_q || (state_q == StClr));
  assign busy      = (state_q != StIdle);
  assign bld_tree  = tree_q;
  assign bld_code  = code_q;
  assign sym_out   = sym_q;

`ifdef CL_DEC_STAT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = 16'd0;
    end else if (sym_valid && sym_ready && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 16'd0;
    else     cnt_q <= cnt_d;
  end

  assign sym_cnt = cnt_q;
`else
  assign sym_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_cl_sym_decoder.sv
// Directed + randomized bench for cl_sym_decoder with a behavioural table-builder model.
module tb_cl_sym_decoder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         busy;
  logic         len_valid = 1'b0;
  logic [3:0]   len_data = 4'd0;
  logic         len_ready;
  logic         bld_rst_n;
  logic         bld_enb;
  logic [115:0] bld_tree;
  logic         bld_fin;
  logic [3:0]   bld_len;
  logic [4:0]   bld_count;
  logic [7:0]   bld_code;
  logic [4:0]   bld_symb;
  logic         bit_valid = 1'b0;
  logic         bit_in = 1'b0;
  logic         bit_ready;
  logic         sym_valid;
  logic [4:0]   sym_out;
  logic         sym_ready = 1'b0;
  logic         err;
  logic [15:0]  sym_cnt;

  int checks = 0;
  int failures = 0;

`ifdef CL_DEC_STAT_EN
  localparam bit Stat = 1'b1;
`else
  localparam bit Stat = 1'b0;
`endif

  cl_sym_decoder dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .len_valid(len_valid), .len_data(len_data), .len_ready(len_ready),
    .bld_rst_n(bld_rst_n), .bld_enb(bld_enb), .bld_tree(bld_tree), .bld_fin(bld_fin),
    .bld_len(bld_len), .bld_count(bld_count), .bld_code(bld_code), .bld_symb(bld_symb),
    .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
    .sym_valid(sym_valid), .sym_out(sym_out), .sym_ready(sym_ready),
    .err(err), .sym_cnt(sym_cnt)
  );

  always #5 clk = ~clk;

  // Canonical code assignment: shorter codes first, ties by symbol index.
  function automatic void canon(input logic [3:0] l [29], output int codes [29]);
    int c;
    c = 0;
    for (int s = 0; s < 29; s++) codes[s] = 0;
    for (int n = 1; n <= 8; n++) begin
      for (int s = 0; s < 29; s++) begin
        if (int'(l[s]) == n) begin
          codes[s] = c;
          c++;
        end
      end
      c = c << 1;
    end
  endfunction

  function automatic void tree_lens(input logic [115:0] t, output logic [3:0] l [29]);
    for (int s = 0; s < 29; s++) l[s] = t[4*s +: 4];
  endfunction

  function automatic logic [115:0] pack(input logic [3:0] l [29]);
    logic [115:0] t;
    t = '0;
    for (int s = 0; s < 29; s++) t[4*s +: 4] = l[s];
    return t;
  endfunction

  function automatic logic [4:0] f_count(input logic [115:0] t, input logic [3:0] q);
    logic [3:0] l [29];
    int n;
    n = 0;
    tree_lens(t, l);
    for (int s = 0; s < 29; s++) if (q != 4'd0 && l[s] == q) n++;
    return 5'(n);
  endfunction

  function automatic logic [4:0] f_symb(input logic [115:0] t, input logic [3:0] q,
                                        input logic [7:0] c);
    logic [3:0] l [29];
    int codes [29];
    tree_lens(t, l);
    canon(l, codes);
    for (int s = 0; s < 29; s++)
      if (q != 4'd0 && l[s] == q && codes[s] == int'(c)) return 5'(s);
    return 5'd0;
  endfunction

  // Builder model: combinational lookups, finishes three enabled cycles after its reset.
  logic [1:0] fin_cnt;
  always_ff @(posedge clk) begin
    if (!bld_rst_n) fin_cnt <= 2'd0;
    else if (bld_enb && fin_cnt != 2'd3) fin_cnt <= fin_cnt + 2'd1;
  end
  assign bld_fin   = (fin_cnt == 2'd3);
  assign bld_count = f_count(bld_tree, bld_len);
  assign bld_symb  = f_symb(bld_tree, bld_len, bld_code);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_bit_ready(input string tag);
    int n;
    n = 0;
    while (bit_ready !== 1'b1 && n < 50) begin
      tick;
      n++;
    end
    chk(tag, bit_ready, 1);
  endtask

  task automatic send_bit(input logic b);
    wait_bit_ready("bit_ready_wait");
    bit_valid = 1'b1;
    bit_in    = b;
    tick;
    bit_valid = 1'b0;
  endtask

  task automatic load_table(input logic [3:0] l [29], input string tag);
    int lows;
    int n;
    lows = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    for (int s = 0; s < 29; s++) begin
      if (s == 0) chk({tag, "_len_ready"}, len_ready, 1);
      len_valid = 1'b1;
      len_data  = l[s];
      if (!bld_rst_n) lows++;
      tick;
    end
    len_valid = 1'b0;
    n = 0;
    while (bit_ready !== 1'b1 && n < 50) begin
      if (!bld_rst_n) lows++;
      tick;
      n++;
    end
    chk({tag, "_built"}, bit_ready, 1);
    chk({tag, "_bld_rst_pulses"}, lows, 1);
    chk({tag, "_tree"}, bld_tree, pack(l));
  endtask

  task automatic decode_sym(input logic [3:0] l [29], input int s, input int hold,
                            input string tag);
    int codes [29];
    canon(l, codes);
    for (int k = int'(l[s]) - 1; k >= 0; k--) send_bit(((codes[s] >> k) & 1) != 0);
    chk({tag, "_early"}, sym_valid, 0);
    tick;
    chk({tag, "_valid"}, sym_valid, 1);
    chk({tag, "_sym"}, sym_out, s);
    for (int h = 0; h < hold; h++) begin
      tick;
      chk({tag, "_hold_valid"}, sym_valid, 1);
      chk({tag, "_hold_sym"}, sym_out, s);
      chk({tag, "_hold_bit_ready"}, bit_ready, 0);
    end
    sym_ready = 1'b1;
    tick;
    sym_ready = 1'b0;
    chk({tag, "_released"}, sym_valid, 0);
  endtask

  logic [3:0] tab_a [29];
  logic [3:0] tab_b [29];
  logic [3:0] tab_z [29];
  logic [3:0] tab_r [29];

  initial begin
    int budget;
    int pick;
    int used [$];
    for (int s = 0; s < 29; s++) begin
      tab_a[s] = 4'd0;
      tab_b[s] = 4'd0;
      tab_z[s] = 4'd0;
    end
    tab_a[0] = 4'd1; tab_a[1] = 4'd1;
    tab_b[0] = 4'd1; tab_b[1] = 4'd2; tab_b[2] = 4'd2;

    // Reset state
    tick;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_len_ready", len_ready, 0);
    chk("rst_bit_ready", bit_ready, 0);
    chk("rst_sym_valid", sym_valid, 0);
    chk("rst_bld_enb", bld_enb, 0);
    chk("rst_err", err, 0);
    chk("rst_bld_rst_n", bld_rst_n, 0);
    chk("rst_tree", bld_tree, 0);
    chk("rst_sym_out", sym_out, 0);
    chk("rst_sym_cnt", sym_cnt, 0);
    chk("rst_bld_len", bld_len, 0);
    rst = 1'b0;
    chk("rst_bld_rst_n_hold", bld_rst_n, 0);
    tick;
    chk("rst_bld_rst_n_release", bld_rst_n, 1);
    chk("idle_busy", busy, 0);

    // Two 1-bit codes
    load_table(tab_a, "ta");
    decode_sym(tab_a, 0, 0, "ta_s0");
    decode_sym(tab_a, 1, 0, "ta_s1");

    // Mixed lengths, back-pressure on first symbol
    load_table(tab_b, "tb");
    chk("tb_tree_low", bld_tree[11:0], 12'h221);
    decode_sym(tab_b, 2, 3, "tb_s2");
    decode_sym(tab_b, 0, 0, "tb_s0");

    // Random prefix-free tables with random symbol streams
    for (int t = 0; t < 3; t++) begin
      budget = 256;
      used.delete();
      for (int s = 0; s < 29; s++) begin
        pick = int'($urandom_range(0, 8));
        if (pick != 0 && (256 >> pick) > budget) pick = 0;
        if (pick != 0) begin
          budget -= 256 >> pick;
          used.push_back(s);
        end
        tab_r[s] = 4'(pick);
      end
      if (used.size() == 0) begin
        tab_r[5] = 4'd3;
        used.push_back(5);
      end
      load_table(tab_r, "rnd");
      for (int k = 0; k < 6; k++)
        decode_sym(tab_r, used[$urandom_range(0, used.size() - 1)], k % 2, "rnd_sym");
    end

    // All-zero table: any 8 bits end in ERR
    load_table(tab_z, "tz");
    for (int k = 0; k < 8; k++) begin
      send_bit(1'($urandom_range(0, 1)));
      if (k == 6) chk("tz_no_err_yet", err, 0);
    end
    tick;
    chk("tz_err", err, 1);
    chk("tz_bit_ready", bit_ready, 0);
    tick;
    tick;
    chk("tz_err_sticky", err, 1);
    chk("tz_sym_valid", sym_valid, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("tz_err_clr", err, 0);
    chk("tz_len_ready", len_ready, 1);

    // Start in DEC after one bit
    load_table(tab_b, "rs");
    decode_sym(tab_b, 0, 0, "rs_s0");
    chk("rs_cnt_one", sym_cnt, Stat ? 16'd1 : 16'd0);
    send_bit(1'b1);
    tick;
    chk("rs_in_dec", bit_ready, 1);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("rs_len_ready", len_ready, 1);
    chk("rs_bit_ready", bit_ready, 0);
    chk("rs_cnt_clr", sym_cnt, 0);
    load_table(tab_a, "rs2");
    decode_sym(tab_a, 1, 0, "rs2_s1");

    // Start while a symbol is pending drops it
    send_bit(1'b0);
    tick;
    chk("drop_valid_before", sym_valid, 1);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("drop_valid_after", sym_valid, 0);
    chk("drop_len_ready", len_ready, 1);
    load_table(tab_a, "rs3");

    // Reset mid-decode
    send_bit(1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sym_valid", sym_valid, 0);
    chk("mid_rst_sym_out", sym_out, 0);
    chk("mid_rst_tree", bld_tree, 0);
    chk("mid_rst_cnt", sym_cnt, 0);
    chk("mid_rst_bld_len", bld_len, 0);
    tick;
    chk("mid_rst_still_idle", sym_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
